mem_wb_stage: RTL and testbench
===============================

MEM_WB_STAGE -- requirements
Module: mem_wb_stage

Interface
REQ-001 Parameter BITS_SIZE, default 32, datapath width.
REQ-002 Parameter BITS_REGS, default 5, register-index width.
REQ-003 Parameter BITS_EXTENSION, default 2, load-size selector width.
REQ-004 i_clk  input  1  the single clock; all state updates on rising edge.
REQ-005 i_reset  input  1  synchronous, active-high reset.
REQ-006 i_step  input  1  advance enable; state updates only when high.
REQ-007 i_exmem_valid  input  1  incoming slot holds a real instruction, not a bubble.
REQ-008 i_mem_dato  input  BITS_SIZE  raw word read from data memory.
REQ-009 i_exmem_alu  input  BITS_SIZE  ALU result.
REQ-010 i_exmem_pc8  input  BITS_SIZE  PC+8 link value.
REQ-011 i_exmem_rd  input  BITS_REGS  destination register index.
REQ-012 i_exmem_reg_write, i_exmem_mem_to_reg, i_exmem_link, i_exmem_unsigned, i_exmem_halt  input  1 each  control flags.
REQ-013 i_exmem_size_filter  input  BITS_EXTENSION  load size: 00 byte, 01 half, 10/11 word.
REQ-014 o_memwb_result  output  BITS_SIZE  write-back value.
REQ-015 o_memwb_rd  output  BITS_REGS  registered destination index.
REQ-016 o_memwb_reg_write  output  1  registered write enable.
REQ-017 o_memwb_halt  output  1  sticky halt-reached flag.
REQ-018 o_retired_count  output  BITS_SIZE  count of retired valid instructions.

Function
REQ-019 Load data SHALL be extended before registering: byte = bits[7:0], half = bits[15:0], sign-extended unless i_exmem_unsigned, zero-extended otherwise; word passes unchanged.
REQ-020 On a rising edge with i_step=1, the stage SHALL capture extended load data, ALU result, PC+8, rd and flags; with i_step=0 all registers SHALL hold.
REQ-021 Latency SHALL be exactly one stepped cycle from inputs to outputs.
REQ-022 o_memwb_result SHALL be combinational from registered values: link -> PC+8; else mem_to_reg -> load data; else ALU result; link has priority over mem_to_reg.
REQ-023 o_memwb_reg_write SHALL be 0 when captured rd = 0, when captured slot invalid, or when halt state is HALTED.
REQ-024 Two-state FSM: RUN, HALTED; RUN -> HALTED on stepped capture of i_exmem_valid=1 and i_exmem_halt=1; HALTED exits only on reset.
REQ-025 The halting instruction itself SHALL retire (counted) with reg_write forced 0; o_memwb_halt SHALL assert in the same cycle its outputs appear.
REQ-026 In HALTED, steps SHALL capture bubbles (valid 0) and the counter SHALL not increment.
REQ-027 o_retired_count SHALL increment by 1 per stepped capture with i_exmem_valid=1 in RUN; it SHALL wrap from 2^BITS_SIZE-1 to 0.
REQ-028 Reset asserted concurrently with i_step SHALL take priority; no capture occurs.

Reset
REQ-029 On reset: all data registers 0, rd 0, every flag 0, valid 0, FSM RUN, o_memwb_result 0, o_memwb_reg_write 0, o_memwb_halt 0, o_retired_count 0.
REQ-030 Reset mid-operation (including in HALTED) SHALL return to these values on the next edge regardless of i_step.

Structure
REQ-031 Load-size codes and FSM state encodings SHALL reside in the shared pipeline package.
REQ-032 Extension logic SHALL be one sub-module, load_extend, purely combinational.

Verification
REQ-033 LB: mem 0x000000F0, size 00, signed, mem_to_reg=1, rd=3, step -> result 0xFFFFFFF0, reg_write 1, rd 3.
REQ-034 LHU: mem 0x1234ABCD, size 01, unsigned -> result 0x0000ABCD; same with signed -> 0xFFFFABCD.
REQ-035 Link priority: link=1, mem_to_reg=1, pc8 0x00000040 -> result 0x00000040; rd=0 with reg_write=1 -> o_memwb_reg_write 0.
REQ-036 Hold: capture ALU 0x55, then step=0 with inputs changed for 5 cycles -> outputs stay 0x55, count unchanged.
REQ-037 Halt: 3 valid instructions then valid halt, then 2 more steps -> count 4, o_memwb_halt 1, reg_write 0 thereafter; reset -> all zero, RUN.
REQ-038 Wrap: count preloaded by 2^32-1 valid steps (or forced) plus one valid step -> count 0.

Source files
------------

// File: rtl/mem_wb_stage_pkg.sv
// rtl/mem_wb_stage_pkg.sv - shared pipeline encodings for the memory/write-back stage
package mem_wb_stage_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } wb_state_e;

endpackage

// File: rtl/mem_wb_stage_load_extend.sv
// rtl/mem_wb_stage_load_extend.sv - combinational byte/half/word load extension
module load_extend
    import mem_wb_stage_pkg::*;
#(
    parameter int BITS_SIZE      = 32,
    parameter int BITS_EXTENSION = 2
) (
    input  logic [BITS_SIZE-1:0]      i_data,
    input  logic [BITS_EXTENSION-1:0] i_size,
    input  logic                      i_unsigned,
    output logic [BITS_SIZE-1:0]      o_data
);

    logic signed [7:0]  byte_s;
    logic signed [15:0] half_s;

    assign byte_s = i_data[7:0];
    assign half_s = i_data[15:0];

    // Size casts of signed operands sign-extend; unsigned operands zero-extend.
    always_comb begin
        o_data = i_data;
        if (i_size == BITS_EXTENSION'(SIZE_BYTE)) begin
            o_data = i_unsigned ? BITS_SIZE'(i_data[7:0]) : BITS_SIZE'(byte_s);
        end else if (i_size == BITS_EXTENSION'(SIZE_HALF)) begin
            o_data = i_unsigned ? BITS_SIZE'(i_data[15:0]) : BITS_SIZE'(half_s);
        end
    end

endmodule

// File: rtl/mem_wb_stage.sv
// rtl/mem_wb_stage.sv - MEM/WB pipeline register with halt FSM and retire counter
module mem_wb_stage
    import mem_wb_stage_pkg::*;
#(
    parameter int BITS_SIZE      = 32,
    parameter int BITS_REGS      = 5,
    parameter int BITS_EXTENSION = 2
) (
    input  logic                      i_clk,
    input  logic                      i_reset,
    input  logic                      i_step,
    input  logic                      i_exmem_valid,
    input  logic [BITS_SIZE-1:0]      i_mem_dato,
    input  logic [BITS_SIZE-1:0]      i_exmem_alu,
    input  logic [BITS_SIZE-1:0]      i_exmem_pc8,
    input  logic [BITS_REGS-1:0]      i_exmem_rd,
    input  logic                      i_exmem_reg_write,
    input  logic                      i_exmem_mem_to_reg,
    input  logic                      i_exmem_link,
    input  logic                      i_exmem_unsigned,
    input  logic                      i_exmem_halt,
    input  logic [BITS_EXTENSION-1:0] i_exmem_size_filter,
    output logic [BITS_SIZE-1:0]      o_memwb_result,
    output logic [BITS_REGS-1:0]      o_memwb_rd,
    output logic                      o_memwb_reg_write,
    output logic                      o_memwb_halt,
    output logic [BITS_SIZE-1:0]      o_retired_count
);

    logic [BITS_SIZE-1:0] load_ext;

    logic [BITS_SIZE-1:0] load_q, load_d;
    logic [BITS_SIZE-1:0] alu_q, alu_d;
    logic [BITS_SIZE-1:0] pc8_q, pc8_d;
    logic [BITS_SIZE-1:0] count_q, count_d;
    logic [BITS_REGS-1:0] rd_q, rd_d;
    logic                 reg_write_q, reg_write_d;
    logic                 mem_to_reg_q, mem_to_reg_d;
    logic                 link_q, link_d;
    logic                 valid_q, valid_d;
    wb_state_e            state_q;

    load_extend #(
        .BITS_SIZE      (BITS_SIZE),
        .BITS_EXTENSION (BITS_EXTENSION)
    ) u_load_extend (
        .i_data     (i_mem_dato),
        .i_size     (i_exmem_size_filter),
        .i_unsigned (i_exmem_unsigned),
        .o_data     (load_ext)
    );

    // Once halted, steps only inject bubbles; datapath registers keep their last contents.
    always_comb begin
        load_d       = load_q;
        alu_d        = alu_q;
        pc8_d        = pc8_q;
        count_d      = count_q;
        rd_d         = rd_q;
        reg_write_d  = reg_write_q;
        mem_to_reg_d = mem_to_reg_q;
        link_d       = link_q;
        valid_d      = valid_q;
        if (i_step) begin
            if (state_q == ST_HALTED) begin
                valid_d = 1'b0;
            end else begin
                load_d       = load_ext;
                alu_d        = i_exmem_alu;
                pc8_d        = i_exmem_pc8;
                rd_d         = i_exmem_rd;
                reg_write_d  = i_exmem_reg_write;
                mem_to_reg_d = i_exmem_mem_to_reg;
                link_d       = i_exmem_link;
                valid_d      = i_exmem_valid;
                if (i_exmem_valid) begin
                    count_d = count_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            load_q       <= '0;
            alu_q        <= '0;
            pc8_q        <= '0;
            count_q      <= '0;
            rd_q         <= '0;
            reg_write_q  <= 1'b0;
            mem_to_reg_q <= 1'b0;
            link_q       <= 1'b0;
            valid_q      <= 1'b0;
            state_q      <= ST_RUN;
        end else begin
            load_q       <= load_d;
            alu_q        <= alu_d;
            pc8_q        <= pc8_d;
            count_q      <= count_d;
            rd_q         <= rd_d;
            reg_write_q  <= reg_write_d;
            mem_to_reg_q <= mem_to_reg_d;
            link_q       <= link_d;
            valid_q      <= valid_d;
            if (i_step && state_q == ST_RUN && i_exmem_valid && i_exmem_halt) begin
                state_q <= ST_HALTED;
            end
        end
    end

    assign o_memwb_result    = link_q ? pc8_q : (mem_to_reg_q ? load_q : alu_q);
    assign o_memwb_rd        = rd_q;
    // The halting instruction's outputs appear together with HALTED, so its write is masked too.
    assign o_memwb_reg_write = reg_write_q && valid_q && (rd_q != '0) && (state_q != ST_HALTED);
    assign o_memwb_halt      = (state_q == ST_HALTED);
    assign o_retired_count   = count_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb/tb_mem_wb_stage.sv - self-checking bench for mem_wb_stage
module tb_mem_wb_stage;

    logic        clk = 1'b0;
    logic        reset, step, valid, rw, mtr, lnk, uns, hlt;
    logic [1:0]  sz;
    logic [31:0] mem, alu, pc8;
    logic [4:0]  rd;

    logic [31:0] o_result, o_count;
    logic [4:0]  o_rd;
    logic        o_we, o_halt;

    logic [15:0] n_result, n_count;
    logic [4:0]  n_rd;
    logic        n_we, n_halt;

    int total = 0;
    int bad   = 0;
    bit cmp_en = 1'b0;

    // Behavioural model of the 32-bit instance
    logic [31:0] m_result, m_count;
    logic [4:0]  m_rd;
    logic        m_we, m_valid, m_halted;

    always #5 clk = ~clk;

    mem_wb_stage dut (
        .i_clk(clk), .i_reset(reset), .i_step(step), .i_exmem_valid(valid),
        .i_mem_dato(mem), .i_exmem_alu(alu), .i_exmem_pc8(pc8), .i_exmem_rd(rd),
        .i_exmem_reg_write(rw), .i_exmem_mem_to_reg(mtr), .i_exmem_link(lnk),
        .i_exmem_unsigned(uns), .i_exmem_halt(hlt), .i_exmem_size_filter(sz),
        .o_memwb_result(o_result), .o_memwb_rd(o_rd), .o_memwb_reg_write(o_we),
        .o_memwb_halt(o_halt), .o_retired_count(o_count)
    );

    // Narrow instance so the retire counter wrap is reachable in a short run
    mem_wb_stage #(.BITS_SIZE(16), .BITS_REGS(5), .BITS_EXTENSION(2)) dut_n (
        .i_clk(clk), .i_reset(reset), .i_step(step), .i_exmem_valid(valid),
        .i_mem_dato(mem[15:0]), .i_exmem_alu(alu[15:0]), .i_exmem_pc8(pc8[15:0]), .i_exmem_rd(rd),
        .i_exmem_reg_write(rw), .i_exmem_mem_to_reg(mtr), .i_exmem_link(lnk),
        .i_exmem_unsigned(uns), .i_exmem_halt(hlt), .i_exmem_size_filter(sz),
        .o_memwb_result(n_result), .o_memwb_rd(n_rd), .o_memwb_reg_write(n_we),
        .o_memwb_halt(n_halt), .o_retired_count(n_count)
    );

    function automatic logic [31:0] ext(input logic [31:0] d, input logic [1:0] s, input logic u);
        case (s)
            2'b00:   ext = u ? {24'h0, d[7:0]}  : {{24{d[7]}}, d[7:0]};
            2'b01:   ext = u ? {16'h0, d[15:0]} : {{16{d[15]}}, d[15:0]};
            default: ext = d;
        endcase
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_result <= '0; m_count <= '0; m_rd <= '0;
            m_we <= 1'b0; m_valid <= 1'b0; m_halted <= 1'b0;
        end else if (step) begin
            if (m_halted) begin
                m_valid <= 1'b0;
                m_we    <= 1'b0;
            end else begin
                m_valid  <= valid;
                m_rd     <= rd;
                m_result <= lnk ? pc8 : (mtr ? ext(mem, sz, uns) : alu);
                m_we     <= rw && valid && (rd != 0) && !hlt;
                if (valid && hlt) m_halted <= 1'b1;
                if (valid) m_count <= m_count + 1;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            if (!m_halted || m_valid) chk("model result", o_result, m_result);
            chk("model rd", {27'h0, o_rd}, {27'h0, m_rd});
            chk("model we", {31'h0, o_we}, {31'h0, m_we});
            chk("model halt", {31'h0, o_halt}, {31'h0, m_halted});
            chk("model count", o_count, m_count);
        end
    end

    task automatic drive(input logic st, input logic v, input logic w, input logic m2r,
                         input logic l, input logic u, input logic h, input logic [1:0] s,
                         input logic [31:0] md, input logic [31:0] a, input logic [31:0] p,
                         input logic [4:0] r);
        step = st; valid = v; rw = w; mtr = m2r; lnk = l; uns = u; hlt = h;
        sz = s; mem = md; alu = a; pc8 = p; rd = r;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic st);
        reset = 1'b1;
        drive(st, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 32'h0, 32'h99, 32'h0, 5'd9);
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 5'd0);
        do_reset(1'b1);
        cmp_en = 1'b1;
        chk("reset result", o_result, 32'h0);
        chk("reset count", o_count, 32'h0);
        chk("reset we/halt", {30'h0, o_we, o_halt}, 32'h0);

        // LB signed
        drive(1, 1, 1, 1, 0, 0, 0, 2'b00, 32'h000000F0, 32'h1, 32'h2, 5'd3);
        chk("lb result", o_result, 32'hFFFFFFF0);
        chk("lb we", {31'h0, o_we}, 32'h1);
        chk("lb rd", {27'h0, o_rd}, 32'd3);
        // LHU then LH
        drive(1, 1, 1, 1, 0, 1, 0, 2'b01, 32'h1234ABCD, 32'h1, 32'h2, 5'd4);
        chk("lhu result", o_result, 32'h0000ABCD);
        drive(1, 1, 1, 1, 0, 0, 0, 2'b01, 32'h1234ABCD, 32'h1, 32'h2, 5'd4);
        chk("lh result", o_result, 32'hFFFFABCD);
        drive(1, 1, 1, 1, 0, 0, 0, 2'b11, 32'hDEADBEEF, 32'h1, 32'h2, 5'd4);
        chk("lw result", o_result, 32'hDEADBEEF);
        drive(1, 1, 1, 1, 0, 1, 0, 2'b00, 32'h0000007F, 32'h1, 32'h2, 5'd4);
        chk("lbu result", o_result, 32'h0000007F);
        // Link beats mem_to_reg; rd 0 suppresses write
        drive(1, 1, 1, 1, 1, 0, 0, 2'b10, 32'h11111111, 32'h22, 32'h00000040, 5'd0);
        chk("link result", o_result, 32'h00000040);
        chk("rd0 we", {31'h0, o_we}, 32'h0);
        drive(1, 1, 1, 0, 0, 0, 0, 2'b10, 32'h11111111, 32'h77, 32'h40, 5'd6);
        chk("alu result", o_result, 32'h77);
        chk("count after 7", o_count, 32'd7);

        // Hold
        do_reset(1'b1);
        drive(1, 1, 1, 0, 0, 0, 0, 2'b10, 32'h0, 32'h55, 32'h0, 5'd5);
        for (int i = 0; i < 5; i++) begin
            drive(0, 1, 1, 1, 1, 0, 0, 2'b00, 32'hA0 + i, 32'h66 + i, 32'h80 + i, 5'd7);
            chk("hold result", o_result, 32'h55);
            chk("hold count", o_count, 32'd1);
        end
        // Bubble in RUN
        drive(1, 0, 1, 0, 0, 0, 0, 2'b10, 32'h0, 32'h12, 32'h0, 5'd4);
        chk("bubble we", {31'h0, o_we}, 32'h0);
        chk("bubble count", o_count, 32'd1);

        // Halt sequence
        do_reset(1'b0);
        for (int i = 1; i <= 3; i++) begin
            drive(1, 1, 1, 0, 0, 0, 0, 2'b10, 32'h0, 32'h100 + i, 32'h0, 5'(i));
            chk("pre-halt we", {31'h0, o_we}, 32'h1);
        end
        drive(1, 1, 1, 0, 0, 0, 1, 2'b10, 32'h0, 32'h200, 32'h0, 5'd7);
        chk("halt flag", {31'h0, o_halt}, 32'h1);
        chk("halt we", {31'h0, o_we}, 32'h0);
        chk("halt count", o_count, 32'd4);
        for (int i = 0; i < 2; i++) begin
            drive(1, 1, 1, 0, 0, 0, 0, 2'b10, 32'h0, 32'h300, 32'h0, 5'd8);
            chk("halted count", o_count, 32'd4);
            chk("halted we", {31'h0, o_we}, 32'h0);
            chk("halted flag", {31'h0, o_halt}, 32'h1);
        end
        do_reset(1'b1);
        chk("post-halt reset halt", {31'h0, o_halt}, 32'h0);
        chk("post-halt reset count", o_count, 32'h0);
        chk("post-halt reset result", o_result, 32'h0);

        // Wrap on the narrow counter
        for (int i = 1; i <= 65536; i++) begin
            drive(1, 1, 1, 0, 0, 0, 0, 2'b10, 32'h0, 32'h5, 32'h0, 5'd1);
            if (i == 65535) chk("narrow count max", {16'h0, n_count}, 32'h0000FFFF);
        end
        chk("narrow count wrap", {16'h0, n_count}, 32'h0);
        chk("wide count", o_count, 32'd65536);

        drive(0, 0, 0, 0, 0, 0, 0, 2'b10, 32'h0, 32'h0, 32'h0, 5'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
